pwm_decoder: RTL

- Receive-side counterpart of the board's PWM generator. Samples an incoming PWM line and measures its period and high time.
- Converts the duty cycle back to a LEVEL_BITS brightness/level code, i.e. the same code space that drives the generator.
- Used for loopback self-test (generator output wired to a GPIO input) and for reading external PWM sources.
- Reports loss of signal when the line stays static.

---
 rtl/pwm_pkg.sv | 6 +
 rtl/pwm_serial_div.sv | 56 +++++
 rtl/pwm_decoder.sv | 93 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and decoder state encoding shared by the PWM generator and decoder.
package pwm_pkg;
    localparam int DEF_LEVEL_BITS = 4;
    localparam logic [DEF_LEVEL_BITS-1:0] LEVEL_FULL = '1;
    typedef enum logic [1:0] {DISARMED, ARMED, DIVIDE} decState_t;
endpackage

// File: rtl/pwm_serial_div.sv
// pwm_serial_div: restoring unsigned divider, one quotient bit per cycle, start/busy/done handshake.
module pwm_serial_div #(
    parameter int NUM_BITS  = 21,
    parameter int DEN_BITS  = 16,
    parameter int QUOT_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_BITS-1:0]  num,
    input  logic [DEN_BITS-1:0]  den,
    output logic                 busy,
    output logic                 done,
    output logic [QUOT_BITS-1:0] quot
);
    localparam int REM_BITS = NUM_BITS - QUOT_BITS;
    localparam int STEP_BITS = $clog2(QUOT_BITS + 1);
    localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(QUOT_BITS - 1);

    logic [REM_BITS-1:0] rem;
    logic [DEN_BITS-1:0] denReg;
    logic [QUOT_BITS-1:0] numLow, qReg;
    logic [STEP_BITS-1:0] step;
    logic [REM_BITS:0] trial;
    logic qBit;

    // the caller guarantees num < den * 2^QUOT_BITS, so the upper numerator bits start below den
    assign trial = {rem, numLow[QUOT_BITS-1]};
    assign qBit = trial >= (REM_BITS + 1)'(denReg);
    assign done = busy && step == LAST_STEP;
    assign quot = {qReg[QUOT_BITS-2:0], qBit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            denReg <= '0;
            numLow <= '0;
            qReg   <= '0;
            step   <= '0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            rem    <= num[NUM_BITS-1:QUOT_BITS];
            numLow <= num[QUOT_BITS-1:0];
            denReg <= den;
            qReg   <= '0;
            step   <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            rem    <= qBit ? REM_BITS'(trial - (REM_BITS + 1)'(denReg)) : trial[REM_BITS-1:0];
            numLow <= numLow << 1;
            qReg   <= quot;
            step   <= step + STEP_BITS'(1);
            busy   <= !done;
        end
    end
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures period and high time of an incoming PWM line and turns
// the duty cycle back into a level code; flags loss of signal on a static line.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int LEVEL_BITS     = DEF_LEVEL_BITS,
    parameter int CNT_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwm_in,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  level_valid,
    output logic [CNT_BITS-1:0]   period_cycles,
    output logic                  no_signal
);
    localparam int NUM_BITS = CNT_BITS + LEVEL_BITS + 1;
    localparam int Q_BITS = LEVEL_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] TIMEOUT = CNT_BITS'(TIMEOUT_CYCLES);

    logic syncA, s, sDly, rise, timeout;
    logic [CNT_BITS-1:0] perCnt, highCnt;
    decState_t state;
    logic divStart, divBusy, divDone;
    logic [NUM_BITS-1:0] divNum;
    logic [Q_BITS-1:0] divQuot;

    assign rise = s & ~sDly;
    // a rise always wins so a long-static line can re-arm even with a saturated counter
    assign timeout = !rise && state != DIVIDE && perCnt >= TIMEOUT;
    assign divStart = state == ARMED && rise && !divBusy;
    assign divNum = {1'b0, highCnt, {LEVEL_BITS{1'b0}}} + NUM_BITS'(perCnt >> 1);

    pwm_serial_div #(
        .NUM_BITS (NUM_BITS),
        .DEN_BITS (CNT_BITS),
        .QUOT_BITS(Q_BITS)
    ) uDiv (
        .clk  (clk),
        .rst_n(rst_n),
        .start(divStart),
        .num  (divNum),
        .den  (perCnt),
        .busy (divBusy),
        .done (divDone),
        .quot (divQuot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA         <= 1'b0;
            s             <= 1'b0;
            sDly          <= 1'b0;
            perCnt        <= '0;
            highCnt       <= '0;
            state         <= DISARMED;
            level         <= '0;
            level_valid   <= 1'b0;
            period_cycles <= '0;
            no_signal     <= 1'b1;
        end else begin
            syncA       <= pwm_in;
            s           <= syncA;
            sDly        <= s;
            perCnt      <= rise ? CNT_BITS'(1) : perCnt == CNT_MAX ? perCnt : perCnt + CNT_BITS'(1);
            highCnt     <= rise ? CNT_BITS'(1) : highCnt == CNT_MAX ? highCnt : highCnt + CNT_BITS'(s);
            level_valid <= 1'b0;
            if (timeout) begin
                level         <= s ? '1 : '0;
                level_valid   <= !no_signal;
                no_signal     <= 1'b1;
                period_cycles <= '0;
                state         <= DISARMED;
            end else begin
                case (state)
                    DISARMED: if (rise) state <= ARMED;
                    ARMED: if (divStart) begin
                        period_cycles <= perCnt;
                        state         <= DIVIDE;
                    end
                    default: if (divDone) begin
                        level       <= divQuot[LEVEL_BITS] ? '1 : divQuot[LEVEL_BITS-1:0];
                        level_valid <= 1'b1;
                        no_signal   <= 1'b0;
                        state       <= ARMED;
                    end
                endcase
            end
        end
    end
endmodule
